spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
SPI responder: the target-side counterpart of the existing SPI master, for loopback verification and for FPGA-as-peripheral builds.
- Oversamples SCLK_i, CS_i and MOSI_i on GCLK.
- Supports all four SPI modes and 32/16/8/4-bit words, MSB first.
- Shifts tx_data_i out on MISO_o and presents each received word on rx_data_o with a one-cycle valid pulse.
- Sits between the pad ring and the register/AXI side.

Parameters:
SYNC_STAGES, 2, synchronizer flops on SCLK_i/CS_i/MOSI_i (legal: 2 or 3)
MISO_IDLE, 1'b0, value driven on MISO_o while CS_i is inactive

Ports:
GCLK  input  1  system clock; SCLK_i must be at most GCLK/8
RST  input  1  reset, synchronous, active-high
spi_mode_i  input  2  [1]=CPOL, [0]=CPHA; captured at frame start
word_len_i  input  2  0:32, 1:16, 2:8, 3:4 bits; captured at frame start
tx_data_i  input  32  word to transmit, right-aligned; captured at frame start and at each word boundary
rx_data_o  output  32  last received word, right-aligned, upper bits zero
rx_valid_o  output  1  one-GCLK pulse when rx_data_o updates
busy_o  output  1  high while a frame is active
frame_err_o  output  1  one-GCLK pulse when CS_i rises mid-word
SCLK_i  input  1  SPI clock from master
CS_i  input  1  chip select, active-low
MOSI_i  input  1  serial data in
MISO_o  output  1  serial data out

Behaviour:
- Reset: rx_data_o=0, rx_valid_o=0, busy_o=0, frame_err_o=0, MISO_o=MISO_IDLE, state=IDLE, synchronizer flops = 1 for CS and 0 for the others.
- Synchronization: SYNC_STAGES flops per input, plus one history flop for edge detection. Edges are decided on the synchronized signals only.
- Sample edge: SCLK rising for modes 0 and 3, falling for modes 1 and 2. Shift edge is the opposite SCLK edge.
- N = word length; bit_cnt is 5 bits and counts N-1 down to 0.

IDLE:
- busy_o=0, MISO_o=MISO_IDLE.
- On synchronized CS falling edge:
  - latch mode and length;
  - tx_shift <= tx_data_i, bit_cnt <= N-1, busy_o <= 1;
  - if CPHA=0, MISO_o <= tx_data_i[N-1] in the same cycle;
  - go to ACTIVE.
- A CS level that is low without a falling edge (e.g. after reset) never starts a frame.

ACTIVE:
- Sample edge:
  - rx_shift <= {rx_shift[30:0], MOSI_sync};
  - if bit_cnt==0: on the next GCLK, rx_data_o <= rx_shift masked to N bits and rx_valid_o=1; then bit_cnt <= N-1 and tx_shift <= tx_data_i (next word, same frame);
  - otherwise bit_cnt <= bit_cnt-1.
- Shift edge:
  - CPHA=1: MISO_o <= tx_shift[bit_cnt].
  - CPHA=0: MISO_o <= tx_shift[bit_cnt], but the very first shift edge of the frame is ignored when CPHA=0 and CPOL-idle edge semantics make it a leading edge. Shift edges before any sample edge are ignored.
- Latency: rx_valid_o rises 1 GCLK after the final sample edge is detected, i.e. 2+SYNC_STAGES GCLKs after the pin edge.
- CS rising edge:
  - if bit_cnt != N-1 (partial word): frame_err_o pulses for 1 GCLK and the partial word is discarded, with no rx_valid_o;
  - always: busy_o <= 0, MISO_o <= MISO_IDLE, return to IDLE.
- Simultaneous CS rise and final sample edge in the same GCLK: the word completes (rx_valid_o) and frame_err_o stays 0.
- Mode/length changes while ACTIVE are ignored until the next frame.
- RST mid-frame: immediate return to the reset state; the rest of the frame is ignored until CS rises and falls again.

Optional Feature:
SPI_SLAVE_OVERRUN_EN
- Defined: adds input rx_ack_i (1) and output overrun_o (1).
  - rx_pending sets on rx_valid_o and clears on rx_ack_i; ack wins if both occur in the same cycle.
  - If rx_valid_o fires while rx_pending=1, overrun_o sets and is sticky until RST. rx_data_o is still overwritten.
- Undefined: neither port exists and no pending tracking is done.

Test Plan:
- Mode 0, 8-bit, tx_data_i=0xA5, MOSI stream 0x3C at GCLK/16 -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o=0x0000003C with one rx_valid_o pulse; busy_o high only while CS low.
- Modes 1/2/3, 16-bit, tx=0xBEEF, MOSI 0x1234 -> rx_data_o=0x00001234 and MISO matches 0xBEEF MSB-first in every mode.
- 32-bit, two back-to-back words in one CS frame, tx 0xDEADBEEF then 0x01234567, MOSI 0xCAFEF00D then 0x89ABCDEF -> two rx_valid_o pulses with those values; MISO carries both tx words.
- 4-bit frame, CS raised after 2 SCLK cycles -> frame_err_o pulses once, no rx_valid_o, rx_data_o unchanged, MISO_o=MISO_IDLE.
- RST asserted mid-frame with CS held low -> outputs return to reset values; the next CS fall with 8-bit 0x81 is received correctly.
- With SPI_SLAVE_OVERRUN_EN: two 8-bit words and no rx_ack_i -> overrun_o=1 after the second rx_valid_o; with rx_ack_i between the words, overrun_o stays 0.

Source files
------------

// File: rtl/spi_slave.sv
// SPI target: oversamples SCLK/CS/MOSI on GCLK, supports modes 0-3 and 32/16/8/4-bit words, MSB first.
// Optional receive-overrun tracking (rx_ack_i/overrun_o) is enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave #(
  parameter int   SYNC_STAGES = 2,
  parameter logic MISO_IDLE   = 1'b0
) (
  input  logic        GCLK,
  input  logic        RST,
  input  logic [1:0]  spi_mode_i,
  input  logic [1:0]  word_len_i,
  input  logic [31:0] tx_data_i,
  output logic [31:0] rx_data_o,
  output logic        rx_valid_o,
  output logic        busy_o,
  output logic        frame_err_o,
`ifdef SPI_SLAVE_OVERRUN_EN
  input  logic        rx_ack_i,
  output logic        overrun_o,
`endif
  input  logic        SCLK_i,
  input  logic        CS_i,
  input  logic        MOSI_i,
  output logic        MISO_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  function automatic logic [4:0] last_bit(input logic [1:0] len);
    case (len)
      2'd0:    return 5'd31;
      2'd1:    return 5'd15;
      2'd2:    return 5'd7;
      default: return 5'd3;
    endcase
  endfunction

  function automatic logic [31:0] len_mask(input logic [1:0] len);
    case (len)
      2'd0:    return 32'hFFFF_FFFF;
      2'd1:    return 32'h0000_FFFF;
      2'd2:    return 32'h0000_00FF;
      default: return 32'h0000_000F;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, cs_hist_q;
  logic [SYNC_STAGES:0]   flush_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: CS synchronizer resets high (inactive) so reset never fakes a chip-select assertion.
  always_ff @(posedge GCLK) begin
    if (RST) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
      flush_q     <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI_i};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic sample_edge, shift_edge;

  state_t      state_q;
  logic [1:0]  mode_q, len_q;
  logic [31:0] tx_shift_q, rx_shift_q;
  logic [4:0]  bit_cnt_q;
  logic        seen_sample_q, word_done_q, armed_q;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;

  // Modes 0 and 3 (CPOL == CPHA) sample on rising SCLK, modes 1 and 2 on falling.
  assign sample_edge = (mode_q[1] ^ mode_q[0]) ? sclk_fall : sclk_rise;
  assign shift_edge  = (mode_q[1] ^ mode_q[0]) ? sclk_rise : sclk_fall;

  always_ff @(posedge GCLK) begin
    if (RST) begin
      state_q       <= IDLE;
      mode_q        <= 2'd0;
      len_q         <= 2'd0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      bit_cnt_q     <= 5'd0;
      seen_sample_q <= 1'b0;
      word_done_q   <= 1'b0;
      armed_q       <= 1'b0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      busy_o        <= 1'b0;
      frame_err_o   <= 1'b0;
      MISO_o        <= MISO_IDLE;
    end else begin
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      word_done_q <= 1'b0;

      if (word_done_q) begin
        rx_data_o  <= rx_shift_q & len_mask(len_q);
        rx_valid_o <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          busy_o <= 1'b0;
          MISO_o <= MISO_IDLE;
          // Only a CS seen high after reset may start a frame; a CS held low across reset is ignored.
          if (flush_q[SYNC_STAGES] && cs_s && cs_hist_q)
            armed_q <= 1'b1;
          if (cs_fall && armed_q) begin
            mode_q        <= spi_mode_i;
            len_q         <= word_len_i;
            tx_shift_q    <= tx_data_i;
            bit_cnt_q     <= last_bit(word_len_i);
            seen_sample_q <= 1'b0;
            busy_o        <= 1'b1;
            if (!spi_mode_i[0])
              MISO_o <= tx_data_i[last_bit(word_len_i)];
            state_q <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (sample_edge) begin
            rx_shift_q    <= {rx_shift_q[30:0], mosi_s};
            seen_sample_q <= 1'b1;
            if (bit_cnt_q == 5'd0) begin
              word_done_q <= 1'b1;
              bit_cnt_q   <= last_bit(len_q);
              tx_shift_q  <= tx_data_i;
            end else begin
              bit_cnt_q <= bit_cnt_q - 5'd1;
            end
          end else if (shift_edge && (mode_q[0] || seen_sample_q)) begin
            MISO_o <= tx_shift_q[bit_cnt_q];
          end

          if (cs_rise) begin
            if (!(sample_edge && bit_cnt_q == 5'd0) && bit_cnt_q != last_bit(len_q))
              frame_err_o <= 1'b1;
            busy_o  <= 1'b0;
            MISO_o  <= MISO_IDLE;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_pending_q;

  // Acknowledge beats a simultaneous new word; overrun stays set until reset.
  always_ff @(posedge GCLK) begin
    if (RST) begin
      rx_pending_q <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (rx_valid_o && rx_pending_q)
        overrun_o <= 1'b1;
      if (rx_ack_i)
        rx_pending_q <= 1'b0;
      else if (rx_valid_o)
        rx_pending_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as SPI master at GCLK/16 and checks MISO, received words and flags.
module tb_spi_slave;

  localparam int HALF = 8;

  logic        GCLK = 1'b0;
  logic        RST;
  logic [1:0]  spi_mode_i;
  logic [1:0]  word_len_i;
  logic [31:0] tx_data_i;
  logic [31:0] rx_data_o;
  logic        rx_valid_o;
  logic        busy_o;
  logic        frame_err_o;
  logic        SCLK_i, CS_i, MOSI_i;
  logic        MISO_o;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic        rx_ack_i;
  logic        overrun_o;
`endif

  spi_slave #(.SYNC_STAGES(2), .MISO_IDLE(1'b0)) dut (
    .GCLK        (GCLK),
    .RST         (RST),
    .spi_mode_i  (spi_mode_i),
    .word_len_i  (word_len_i),
    .tx_data_i   (tx_data_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
`ifdef SPI_SLAVE_OVERRUN_EN
    .rx_ack_i    (rx_ack_i),
    .overrun_o   (overrun_o),
`endif
    .SCLK_i      (SCLK_i),
    .CS_i        (CS_i),
    .MOSI_i      (MOSI_i),
    .MISO_o      (MISO_o)
  );

  always #5 GCLK = ~GCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  logic [31:0] rx_log[$];

  always @(negedge GCLK) begin
    if (rx_valid_o) begin
      valid_cnt++;
      rx_log.push_back(rx_data_o);
    end
    if (frame_err_o) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge GCLK);
  endtask

  task automatic frame_begin(input logic [1:0] mode, input logic [1:0] len);
    spi_mode_i = mode;
    word_len_i = len;
    SCLK_i     = mode[1];
    wait_clk(HALF);
    CS_i = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    CS_i = 1'b1;
    wait_clk(2 * HALF);
  endtask

  // Shifts n bits MSB first; next_tx is presented after the first bit so it is ready at the word boundary.
  task automatic xfer_word(input logic [1:0] mode, input int n, input logic [31:0] mosi_w,
                           input logic [31:0] next_tx, output logic [31:0] miso_w);
    logic cpol, cpha;
    cpol   = mode[1];
    cpha   = mode[0];
    miso_w = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        MOSI_i = mosi_w[i];
        wait_clk(HALF);
        miso_w[i] = MISO_o;
        SCLK_i = ~cpol;
        wait_clk(HALF);
        if (i == n - 1) tx_data_i = next_tx;
        SCLK_i = cpol;
      end else begin
        SCLK_i = ~cpol;
        MOSI_i = mosi_w[i];
        wait_clk(HALF);
        miso_w[i] = MISO_o;
        SCLK_i = cpol;
        wait_clk(HALF);
        if (i == n - 1) tx_data_i = next_tx;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] miso, miso2;
    int v0, e0;

    RST = 1'b1; CS_i = 1'b1; SCLK_i = 1'b0; MOSI_i = 1'b0;
    spi_mode_i = 2'd0; word_len_i = 2'd0; tx_data_i = '0;
`ifdef SPI_SLAVE_OVERRUN_EN
    rx_ack_i = 1'b0;
`endif
    wait_clk(4);
    check("rst_rx_data", rx_data_o, 32'h0);
    check("rst_rx_valid", rx_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_frame_err", frame_err_o, 1'b0);
    check("rst_miso", MISO_o, 1'b0);
    RST = 1'b0;
    wait_clk(10);

    // Mode 0, 8-bit
    v0 = valid_cnt;
    tx_data_i = 32'hA5;
    frame_begin(2'd0, 2'd2);
    check("m0_busy_active", busy_o, 1'b1);
    xfer_word(2'd0, 8, 32'h3C, 32'hA5, miso);
    check("m0_miso", miso, 32'hA5);
    frame_end();
    check("m0_valid_cnt", valid_cnt - v0, 1);
    check("m0_rx_data", rx_data_o, 32'h3C);
    check("m0_busy_idle", busy_o, 1'b0);
    check("m0_miso_idle", MISO_o, 1'b0);

    // Modes 1..3, 16-bit
    for (int m = 1; m < 4; m++) begin
      v0 = valid_cnt;
      tx_data_i = 32'hBEEF;
      frame_begin(m[1:0], 2'd1);
      xfer_word(m[1:0], 16, 32'h1234, 32'hBEEF, miso);
      frame_end();
      check($sformatf("m%0d_miso", m), miso, 32'hBEEF);
      check($sformatf("m%0d_rx_data", m), rx_data_o, 32'h1234);
      check($sformatf("m%0d_valid_cnt", m), valid_cnt - v0, 1);
    end

    // 32-bit, two words in one frame
    v0 = valid_cnt;
    rx_log.delete();
    tx_data_i = 32'hDEADBEEF;
    frame_begin(2'd0, 2'd0);
    xfer_word(2'd0, 32, 32'hCAFEF00D, 32'h01234567, miso);
    xfer_word(2'd0, 32, 32'h89ABCDEF, 32'h01234567, miso2);
    frame_end();
    check("b2b_valid_cnt", valid_cnt - v0, 2);
    check("b2b_rx0", (rx_log.size() > 0) ? rx_log[0] : 32'hX, 32'hCAFEF00D);
    check("b2b_rx1", (rx_log.size() > 1) ? rx_log[1] : 32'hX, 32'h89ABCDEF);
    check("b2b_miso0", miso, 32'hDEADBEEF);
    check("b2b_miso1", miso2, 32'h01234567);

    // 4-bit frame aborted after 2 SCLK cycles
    v0 = valid_cnt;
    e0 = err_cnt;
    tx_data_i = 32'hF;
    frame_begin(2'd0, 2'd3);
    xfer_word(2'd0, 2, 32'h2, 32'hF, miso);
    check("abort_miso_mid", MISO_o, 1'b1);
    frame_end();
    check("abort_err_cnt", err_cnt - e0, 1);
    check("abort_valid_cnt", valid_cnt - v0, 0);
    check("abort_rx_data", rx_data_o, 32'h89ABCDEF);
    check("abort_miso_idle", MISO_o, 1'b0);
    check("abort_busy", busy_o, 1'b0);

    // Reset mid-frame with CS held low
    tx_data_i = 32'hC3;
    frame_begin(2'd0, 2'd2);
    xfer_word(2'd0, 3, 32'h5, 32'hC3, miso);
    RST = 1'b1;
    wait_clk(2);
    RST = 1'b0;
    check("rstmid_rx_data", rx_data_o, 32'h0);
    check("rstmid_busy", busy_o, 1'b0);
    check("rstmid_miso", MISO_o, 1'b0);
    v0 = valid_cnt;
    e0 = err_cnt;
    xfer_word(2'd0, 8, 32'hFF, 32'hC3, miso);
    check("rstmid_busy_ignored", busy_o, 1'b0);
    check("rstmid_valid_ignored", valid_cnt - v0, 0);
    frame_end();
    check("rstmid_no_err", err_cnt - e0, 0);
    v0 = valid_cnt;
    tx_data_i = 32'h5A;
    frame_begin(2'd0, 2'd2);
    xfer_word(2'd0, 8, 32'h81, 32'h5A, miso);
    frame_end();
    check("rstmid_rx_after", rx_data_o, 32'h81);
    check("rstmid_valid_after", valid_cnt - v0, 1);
    check("rstmid_miso_after", miso, 32'h5A);

`ifdef SPI_SLAVE_OVERRUN_EN
    tx_data_i = 32'h11;
    frame_begin(2'd0, 2'd2);
    xfer_word(2'd0, 8, 32'h12, 32'h22, miso);
    xfer_word(2'd0, 8, 32'h34, 32'h22, miso);
    frame_end();
    check("ovr_set", overrun_o, 1'b1);
    RST = 1'b1;
    wait_clk(2);
    RST = 1'b0;
    wait_clk(10);
    check("ovr_cleared_by_rst", overrun_o, 1'b0);
    frame_begin(2'd0, 2'd2);
    xfer_word(2'd0, 8, 32'h56, 32'h22, miso);
    rx_ack_i = 1'b1;
    wait_clk(1);
    rx_ack_i = 1'b0;
    xfer_word(2'd0, 8, 32'h78, 32'h22, miso);
    frame_end();
    check("ovr_acked", overrun_o, 1'b0);
    check("ovr_rx_data", rx_data_o, 32'h78);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
